// File: rtl/digital_phase_shifter_tdc_clk.sv
// Phase-adjustable 40 MHz clock and masked 320 MHz TDC strobe generator.
// Coarse phase is set in whole clk1280 cycles. Fine phase (half a cycle) comes
// from a negedge re-register of the posedge outputs.
module digital_phase_shifter_tdc_clk (
  input  logic       clk1280,
  input  logic       rstn,
  input  logic       clk40,
  input  logic       enable,
  input  logic [5:0] clockDelay,
  input  logic [7:0] clock320Mask,
  output logic       clk40out,
  output logic       clk320out
);

  localparam int unsigned CntW  = 5;
  localparam int unsigned SlotW = 3;

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic [CntW-1:0]  phase;
  logic [SlotW-1:0] slot;
  logic             c40, c320;
  logic             r40_q, r40_d;
  logic             r320_q, r320_d;
  logic             n40_q, n320_q;
  logic             sel_q;

  // Detect the clk40 rise, advance the phase counter and decode both clock shapes.
  // Outputs stay gated until the first rise after reset has aligned the counter.
  always_comb begin
    rise     = s2_q & ~s3_q;
    cnt_d    = rise ? '0 : cnt_q + CntW'(1);
    locked_d = locked_q | rise;
    phase    = cnt_q - clockDelay[5:1];
    slot     = phase[CntW-1:2];
    c40      = ~phase[CntW-1];
    c320     = clock320Mask[slot] & ~phase[1];
    r40_d    = c40 & enable & locked_q;
    r320_d   = c320 & enable & locked_q;
  end

  // Synchronizer, phase counter and the posedge output stage.
  // The fine-delay select is also registered here. A change of the select
  // then only swaps between two copies that are equal at that instant.
  always_ff @(posedge clk1280 or negedge rstn) begin
    if (!rstn) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      r40_q    <= 1'b0;
      r320_q   <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      s1_q     <= clk40;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      r40_q    <= r40_d;
      r320_q   <= r320_d;
      sel_q    <= clockDelay[0];
    end
  end

  // Half-cycle delayed copies of the posedge outputs.
  always_ff @(negedge clk1280 or negedge rstn) begin
    if (!rstn) begin
      n40_q  <= 1'b0;
      n320_q <= 1'b0;
    end else begin
      n40_q  <= r40_q;
      n320_q <= r320_q;
    end
  end

  // Fine-delay selection between the posedge copies and the negedge copies.
  assign clk40out  = sel_q ? n40_q  : r40_q;
  assign clk320out = sel_q ? n320_q : r320_q;

endmodule

// File: tb/tb_digital_phase_shifter_tdc_clk.sv
// Self-checking bench for digital_phase_shifter_tdc_clk: cycle model plus literal phase checks.
`timescale 1ps/1ps
module tb_digital_phase_shifter_tdc_clk;

  logic       clk1280 = 1'b0;
  logic       rstn = 1'b1;
  logic       clk40 = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] clockDelay = '0;
  logic [7:0] clock320Mask = '0;
  logic       clk40out;
  logic       clk320out;

  digital_phase_shifter_tdc_clk dut (
    .clk1280      (clk1280),
    .rstn         (rstn),
    .clk40        (clk40),
    .enable       (enable),
    .clockDelay   (clockDelay),
    .clock320Mask (clock320Mask),
    .clk40out     (clk40out),
    .clk320out    (clk320out)
  );

  always #390 clk1280 = ~clk1280;

  int checks = 0;
  int errors = 0;
  int k = 0;   // posedge index
  int h = 0;   // half-cycle index of the latest sample point (2k at posedge, 2k+1 at negedge)

  // clk40 generator: 16 high / 16 low cycles, changes on negedge, optional skipped pulse
  bit gen_run = 0, suppress = 0, skip_cur = 0;
  int gen_ph = 0;
  int gen_t0_k = 0;   // posedge index T0 that first samples the latest clk40 rise
  always @(negedge clk1280) begin
    logic v;
    if (!gen_run) begin
      clk40  = 1'b0;
      gen_ph = 0;
    end else begin
      if (gen_ph == 0) begin
        skip_cur = suppress;
        suppress = 0;
      end
      v = !skip_cur && (gen_ph < 16);
      if (v && !clk40) gen_t0_k = k + 1;
      clk40  = v;
      gen_ph = (gen_ph + 1) % 32;
    end
  end

  // Behavioural model: output waveform is a function of posedges since the alignment point
  bit prev40 = 0, locked = 0;
  int anchor = 0;
  int pend[$];
  bit er40 = 0, er320 = 0, en40 = 0, en320 = 0, esel = 0;

  // Edge monitor for the literal checks
  bit p40o = 0, p320o = 0;
  int rise_cnt = 0, fall_cnt = 0, rise_h = 0, prev_rise_h = 0, fall_h = 0;
  logic [7:0] seen320 = '0, seen_last = '0;
  bit seen_odd = 0;

  function automatic int mod64(input int x);
    return ((x % 64) + 64) % 64;
  endfunction

  task automatic compare_outputs();
    bit x40, x320;
    int off;
    x40  = esel ? en40 : er40;
    x320 = esel ? en320 : er320;
    checks++;
    if (clk40out !== x40) begin
      errors++;
      $display("FAIL model_clk40out h=%0d got %b exp %b", h, clk40out, x40);
    end
    checks++;
    if (clk320out !== x320) begin
      errors++;
      $display("FAIL model_clk320out h=%0d got %b exp %b", h, clk320out, x320);
    end
    if (clk40out && !p40o) begin
      prev_rise_h = rise_h;
      rise_h      = h;
      rise_cnt++;
      seen_last   = seen320;
      seen320     = '0;
    end
    if (!clk40out && p40o) begin
      fall_h = h;
      fall_cnt++;
    end
    if (clk320out && !p320o) begin
      off = mod64(h - 2 * (gen_t0_k + 3) - int'(clockDelay));
      if (off % 8 == 0) seen320[off / 8] = 1'b1;
      else seen_odd = 1;
    end
    p40o  = clk40out;
    p320o = clk320out;
  endtask

  initial forever begin
    int p;
    @(posedge clk1280);
    k++;
    h = 2 * k;
    if (!rstn) begin
      prev40 = 0; locked = 0; pend.delete();
      er40 = 0; er320 = 0; en40 = 0; en320 = 0; esel = 0;
    end else begin
      if (clk40 && !prev40) pend.push_back(k + 3);
      prev40 = clk40;
      if (pend.size() > 0 && pend[0] == k) begin
        anchor = k;
        locked = 1;
        void'(pend.pop_front());
      end
      p     = (((k - anchor - int'(clockDelay) / 2) % 32) + 32) % 32;
      er40  = enable && locked && (p < 16);
      er320 = enable && locked && clock320Mask[3'(p / 4)] && ((p % 4) < 2);
      esel  = clockDelay[0];
    end
    #100 compare_outputs();
    @(negedge clk1280);
    h = 2 * k + 1;
    if (!rstn) begin
      en40 = 0; en320 = 0;
    end else begin
      en40 = er40; en320 = er320;
    end
    #100 compare_outputs();
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic wait_rise(input string name);
    int start, n;
    start = rise_cnt;
    n = 0;
    while (rise_cnt == start && n < 200) begin
      @(posedge clk1280);
      n++;
    end
    if (rise_cnt == start) chk({name, "_rise_timeout"}, 0, 1);
  endtask

  task automatic wait_fall(input string name);
    int start, n;
    start = fall_cnt;
    n = 0;
    while (fall_cnt == start && n < 200) begin
      @(posedge clk1280);
      n++;
    end
    if (fall_cnt == start) chk({name, "_fall_timeout"}, 0, 1);
  endtask

  // Rise position in half-steps relative to T0+3, and the following period
  task automatic check_phase(input string name, input int d);
    wait_rise(name);
    chk({name, "_offset"}, mod64(rise_h - 2 * (gen_t0_k + 3)), d);
    wait_rise(name);
    chk({name, "_period"}, rise_h - prev_rise_h, 64);
  endtask

  int sweep[9] = '{0, 1, 2, 3, 59, 60, 61, 62, 63};
  logic [7:0] masks[8] = '{8'hC0, 8'hA0, 8'h90, 8'h88, 8'h84, 8'h82, 8'h81, 8'h03};

  initial begin
    bit odd_total;
    int n;
    #10 rstn = 1'b0;
    repeat (4) @(negedge clk1280);
    #100;
    chk("reset_clk40out", int'(clk40out), 0);
    chk("reset_clk320out", int'(clk320out), 0);

    // Phase zero
    enable = 1'b1;
    clockDelay = 6'd0;
    clock320Mask = 8'hC0;
    @(negedge clk1280);
    #200 rstn = 1'b1;
    repeat (3) @(negedge clk1280);
    chk("low_before_align", int'(clk40out), 0);
    gen_run = 1;
    wait_rise("phase0");
    chk("phase0_t0_plus3", rise_h - 2 * gen_t0_k, 6);
    wait_fall("phase0");
    chk("phase0_high_width", fall_h - rise_h, 32);
    wait_rise("phase0");
    chk("phase0_period", rise_h - prev_rise_h, 64);
    chk("phase0_mask_c0", int'(seen_last), 8'hC0);

    // Delay sweep
    foreach (sweep[i]) begin
      @(negedge clk1280);
      clockDelay = 6'(sweep[i]);
      repeat (40) @(negedge clk1280);
      check_phase($sformatf("delay%0d", sweep[i]), sweep[i]);
    end

    // Mask walk at zero delay
    @(negedge clk1280);
    clockDelay = 6'd0;
    repeat (40) @(negedge clk1280);
    odd_total = 0;
    foreach (masks[i]) begin
      @(negedge clk1280);
      clock320Mask = masks[i];
      wait_rise("maskwalk");
      seen_odd = 0;
      wait_rise("maskwalk");
      odd_total |= seen_odd;
      chk($sformatf("mask_%02h", masks[i]), int'(seen_last), int'(masks[i]));
    end
    chk("mask_pulse_alignment", int'(odd_total), 0);

    // Enable gating
    clock320Mask = 8'hFF;
    wait_rise("enable");
    repeat (5) @(negedge clk1280);
    enable = 1'b0;
    @(posedge clk1280);
    #100;
    chk("enable_off_clk40out", int'(clk40out), 0);
    chk("enable_off_clk320out", int'(clk320out), 0);
    repeat (50) @(negedge clk1280);
    enable = 1'b1;
    repeat (40) @(negedge clk1280);
    check_phase("enable_resume", 0);

    // Missing clk40 pulse
    @(negedge clk1280);
    clockDelay = 6'd7;
    repeat (40) @(negedge clk1280);
    check_phase("pre_missing", 7);
    suppress = 1;
    n = 0;
    while (suppress && n < 100) begin
      @(negedge clk1280);
      n++;
    end
    chk("suppress_taken", int'(suppress), 0);
    repeat (80) @(negedge clk1280);
    check_phase("missing_edge", 7);

    // Reset mid-high
    @(negedge clk1280);
    clockDelay = 6'd0;
    repeat (40) @(negedge clk1280);
    wait_rise("midreset");
    repeat (4) @(negedge clk1280);
    #200 rstn = 1'b0;
    #1;
    chk("midreset_clk40out", int'(clk40out), 0);
    chk("midreset_clk320out", int'(clk320out), 0);
    repeat (3) @(negedge clk1280);
    n = 0;
    while (clk40 && n < 64) begin
      @(negedge clk1280);
      n++;
    end
    #200 rstn = 1'b1;
    wait_rise("midreset");
    chk("midreset_t0_plus3", rise_h - 2 * gen_t0_k, 6);

    // Randomized quasi-static changes, checked cycle by cycle against the model
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(1, 60)) @(negedge clk1280);
      case ($urandom_range(0, 3))
        0: clockDelay = 6'($urandom);
        1: clock320Mask = 8'($urandom);
        2: enable = ~enable;
        default: begin
          clockDelay = 6'($urandom);
          clock320Mask = 8'($urandom);
        end
      endcase
    end
    @(negedge clk1280);
    enable = 1'b1;
    clockDelay = 6'd33;
    repeat (40) @(negedge clk1280);
    check_phase("final_delay33", 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
